// File: rtl/seq_arith_right_shifter_pkg.sv
// Shared definitions for the sequential arithmetic right shifter:
// FSM state encoding and default parameter values.
package seq_arith_right_shifter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_SHAMT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_arith_right_shifter_if.sv
// Producer/consumer handshake bundle for the shifter.
// Both sides use valid/ready: a beat transfers on a rising clock edge
// where valid and ready are both high; valid, once raised, holds its
// payload stable until that edge.
interface seq_arith_right_shifter_if
    import seq_arith_right_shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_sticky;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, out_sticky
    );

    // Shifter side.
    modport slave (
        input  in_valid, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data, out_sticky
    );
endinterface

// File: rtl/seq_arith_right_shifter_asr1_step.sv
// One-bit arithmetic right shift step: sign bit replicated into the MSB,
// the bit falling off the LSB end reported separately for the sticky logic.
module seq_arith_right_shifter_asr1_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             lsb_out
);
    assign q       = {d[WIDTH-1], d[WIDTH-1:1]};
    assign lsb_out = d[0];
endmodule

// File: rtl/seq_arith_right_shifter.sv
// Multi-cycle arithmetic right shifter: one bit per clock with sign
// extension, plus a sticky bit that ORs together every bit shifted out.
// Shift counts at or above WIDTH still run the full count, so the result
// saturates to all sign bits.
module seq_arith_right_shifter
    import seq_arith_right_shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_arith_right_shifter_if.slave    bus,
    output state_t                      dbg_state
);
    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count_q;
    logic               sticky_q;

    logic [WIDTH-1:0]   step_q;
    logic               step_lsb;

    seq_arith_right_shifter_asr1_step #(.WIDTH(WIDTH)) u_step (
        .d       (data_q),
        .q       (step_q),
        .lsb_out (step_lsb)
    );

    // Handshake flags are pure decodes of the state register.
    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_data   = data_q;
    assign bus.out_sticky = sticky_q;
    assign dbg_state      = state_q;

    // Control FSM together with the data, count and sticky registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data_q   <= bus.in_data;
                        count_q  <= bus.in_shamt;
                        sticky_q <= 1'b0;
                        state_q  <= (bus.in_shamt != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    data_q   <= step_q;
                    sticky_q <= sticky_q | step_lsb;
                    count_q  <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Result stays put until the consumer takes it; the
                    // data path is then cleared so IDLE never shows stale data.
                    if (bus.out_ready) begin
                        data_q   <= '0;
                        sticky_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_arith_right_shifter.sv
// Directed bench for seq_arith_right_shifter (WIDTH=4, SHAMT_W=3).
module tb_seq_arith_right_shifter;
    import seq_arith_right_shifter_pkg::*;

    localparam int W  = 4;
    localparam int SW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_arith_right_shifter_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
    state_t dbg_state;

    seq_arith_right_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, measure latency from the accept edge, check result,
    // then hand it off and check the return to an empty IDLE.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [SW-1:0] s,
                         input logic exp_sticky, input int exp_lat, input logic drain);
        int lat;
        logic [W-1:0] exp_d;
        exp_q.push_back(W'($signed(a) >>> s));
        check({name, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = a;
        bus.in_shamt = s;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom_range(0, 15);
        bus.in_shamt = $urandom_range(0, 7);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        exp_d = exp_q.pop_front();
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " out_data"}, 32'(bus.out_data), 32'(exp_d));
        check({name, " out_sticky"}, 32'(bus.out_sticky), 32'(exp_sticky));
        if (drain) begin
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check({name, " out_valid after take"}, 32'(bus.out_valid), 32'd0);
            check({name, " in_ready after take"}, 32'(bus.in_ready), 32'd1);
            check({name, " data cleared"}, 32'(bus.out_data), 32'd0);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [W-1:0]  a;
        logic [SW-1:0] s;
        logic [W-1:0]  exp_d;
        logic          exp_sticky;
        int            exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat;
        logic [W-1:0] mask;
        logic exp_st;

        vecs[0] = '{4'b1000, 3'd1, 4'b1100, 1'b0, 2};
        vecs[1] = '{4'b0111, 3'd2, 4'b0001, 1'b1, 3};
        vecs[2] = '{4'b1011, 3'd0, 4'b1011, 1'b0, 1};
        vecs[3] = '{4'b1001, 3'd7, 4'b1111, 1'b1, 8};
        vecs[4] = '{4'b0110, 3'd5, 4'b0000, 1'b1, 6};
        vecs[5] = '{4'b0101, 3'd1, 4'b0010, 1'b1, 2};
        vecs[6] = '{4'b1110, 3'd3, 4'b1111, 1'b1, 4};
        vecs[7] = '{4'b1000, 3'd3, 4'b1111, 1'b0, 4};
        vecs[8] = '{4'b0100, 3'd2, 4'b0001, 1'b0, 3};
        vecs[9] = '{4'b1111, 3'd4, 4'b1111, 1'b1, 5};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;

        // Reset values while held in reset.
        repeat (2) step();
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_data", 32'(bus.out_data), 32'd0);
        check("rst out_sticky", 32'(bus.out_sticky), 32'd0);
        check("rst state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        // Table-driven directed vectors; expected data taken from the table.
        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].s, vecs[i].exp_sticky,
                  vecs[i].exp_lat, 1'b0);
            check($sformatf("vec%0d table data", i), 32'(bus.out_data), 32'(vecs[i].exp_d));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check($sformatf("vec%0d in_ready after take", i), 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: result held for 5 cycles while new operands are offered.
        do_op("bp", 4'b0111, 3'd1, 1'b1, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'b1000;
            bus.in_shamt = 3'd0;
            bus.out_ready = 1'b0;
            step();
            check($sformatf("bp hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp hold%0d out_data", c), 32'(bus.out_data), 32'(4'b0011));
            check($sformatf("bp hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp in_ready after take", 32'(bus.in_ready), 32'd1);
        // out_ready pulses while IDLE must not create a result from the ignored offers.
        for (int c = 0; c < 4; c++) begin
            bus.out_ready = 1'(c[0]);
            step();
            check($sformatf("bp idle%0d out_valid", c), 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;

        // Reset in the middle of a long shift.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0110;
        bus.in_shamt = 3'd6;
        step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        check("mid state shifting", 32'(dbg_state), 32'(ST_SHIFT));
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid rst out_data", 32'(bus.out_data), 32'd0);
        step();
        rst_n = 1'b1;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.out_valid) lat++;
        end
        check("mid rst no result", 32'(lat), 32'd0);
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);

        // Full sweep against a mask-based sticky model.
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < 8; s++) begin
                if (s == 0)      exp_st = 1'b0;
                else if (s >= W) exp_st = |a[W-1:0];
                else begin
                    mask = W'((1 << s) - 1);
                    exp_st = |(a[W-1:0] & mask);
                end
                do_op($sformatf("sweep a=%0h s=%0d", a, s), a[W-1:0], s[SW-1:0], exp_st, s + 1, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
